// File: rtl/aclk_controller.sv
// aclk_controller
// Main sequencing FSM of the alarm clock. It interprets keypad digits and the
// time/alarm buttons. It drives the key-register shift strobe and the load
// strobes of the alarm register and the current-time counter. It also aborts
// key entry after TIMEOUT_SECS one_second pulses with no new digit.
//
// Optional feature macro: ACLK_FAST_WATCH_EN
//   defined     : fast_watch follows fast_watch_btn while in SHOW_TIME
//   not defined : fast_watch is tied low and fast_watch_btn is ignored
//
// Ports
//   clk            in   system clock, all state updates on posedge
//   reset          in   synchronous active-high reset
//   one_second     in   one-cycle pulse from the time generator
//   key[3:0]       in   keypad code, 0-9 digits, anything else = no key
//   alarm_button   in   level, alarm button held
//   time_button    in   level, time button held
//   fast_watch_btn in   level, fast-watch request (feature build only)
//   reset_count    out  clear time generator sec/min counters
//   load_new_a     out  load key register into alarm register
//   load_new_c     out  load key register into current-time counter
//   show_a         out  display selects alarm time
//   show_new_time  out  display selects key register
//   shift          out  shift current key into key register
//   fast_watch     out  fast-watch request to the time generator
//
// state            | meaning
// -----------------+------------------------------------------------
// SHOW_TIME        | idle, display current time
// KEY_STORED       | one cycle, shift the new digit into key register
// KEY_WAITED       | waiting for the digit key to be released
// KEY_ENTRY        | key released, waiting for next digit or a button
// SHOW_ALARM       | alarm button held, display alarm time
// SET_ALARM_TIME   | one cycle, load key register into alarm register
// SET_CURRENT_TIME | one cycle, load current time and reset counters

module aclk_controller #(
  parameter int         TIMEOUT_SECS = 10,
  parameter logic [3:0] NOKEY        = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic       fast_watch_btn,
  output logic       reset_count,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift,
  output logic       fast_watch
);

  localparam int              CW   = $clog2(TIMEOUT_SECS + 1);
  localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT_SECS);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic            w_digit;
  logic            w_timeout;
  logic            w_in_entry;

  // Codes 11-15 and NOKEY itself all count as "no key".
  assign w_digit    = (key <= 4'd9) && (key != NOKEY);
  assign w_timeout  = (r_count == TMAX);
  assign w_in_entry = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SHOW_TIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Idle timer. It runs only while waiting in the key-entry states, so the
  // KEY_STORED cycle of each new digit restarts it. It saturates at TMAX.
  always_ff @(posedge clk) begin
    if (reset || !w_in_entry) begin
      r_count <= '0;
    end else if (one_second && !w_timeout) begin
      r_count <= r_count + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SHOW_TIME: begin
        if (alarm_button)  w_state_nxt = SHOW_ALARM;
        else if (w_digit)  w_state_nxt = KEY_STORED;
      end
      KEY_STORED: w_state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (!w_digit)       w_state_nxt = KEY_ENTRY;
        else if (w_timeout) w_state_nxt = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)      w_state_nxt = SET_ALARM_TIME;
        else if (time_button)  w_state_nxt = SET_CURRENT_TIME;
        else if (w_digit)      w_state_nxt = KEY_STORED;
        else if (w_timeout)    w_state_nxt = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) w_state_nxt = SHOW_TIME;
      end
      SET_ALARM_TIME:   w_state_nxt = SHOW_TIME;
      SET_CURRENT_TIME: w_state_nxt = SHOW_TIME;
      default:          w_state_nxt = SHOW_TIME;
    endcase
  end

  always_comb begin
    reset_count   = 1'b0;
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    show_a        = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    case (r_state)
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED:       show_new_time = 1'b1;
      KEY_ENTRY:        show_new_time = 1'b1;
      SHOW_ALARM:       show_a        = 1'b1;
      SET_ALARM_TIME:   load_new_a    = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ACLK_FAST_WATCH_EN
  logic r_fast_watch;

  // Sampled against the next state so the registered output is aligned with
  // r_state. It can only be high while the FSM sits in SHOW_TIME and drops in
  // the same cycle the FSM leaves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fast_watch <= 1'b0;
    end else begin
      r_fast_watch <= fast_watch_btn && (w_state_nxt == SHOW_TIME);
    end
  end

  assign fast_watch = r_fast_watch;
`else
  logic w_fast_watch_unused;

  assign w_fast_watch_unused = fast_watch_btn;
  assign fast_watch          = 1'b0;
`endif

endmodule

// File: tb/tb_aclk_controller.sv
// Directed scoreboard bench for aclk_controller. Each stimulus step pushes the
// output vector expected after the next clock edge. A monitor on the falling
// edge pops and compares it.
// Vector order: {reset_count, load_new_a, load_new_c, show_a, show_new_time, shift, fast_watch}

module tb_aclk_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'd10;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       fast_watch_btn = 1'b0;
  logic       reset_count, load_new_a, load_new_c, show_a, show_new_time, shift, fast_watch;

  localparam logic [3:0] NK     = 4'd10;
  localparam logic [6:0] E_IDLE  = 7'b000_0000;
  localparam logic [6:0] E_SHIFT = 7'b000_0110;
  localparam logic [6:0] E_NEW   = 7'b000_0100;
  localparam logic [6:0] E_LDC   = 7'b101_0000;
  localparam logic [6:0] E_LDA   = 7'b010_0000;
  localparam logic [6:0] E_SHA   = 7'b000_1000;
`ifdef ACLK_FAST_WATCH_EN
  localparam logic [6:0] E_FW    = 7'b000_0001;
`else
  localparam logic [6:0] E_FW    = 7'b000_0000;
`endif

  aclk_controller #(.TIMEOUT_SECS(10), .NOKEY(4'd10)) dut (
    .clk            (clk),
    .reset          (reset),
    .one_second     (one_second),
    .key            (key),
    .alarm_button   (alarm_button),
    .time_button    (time_button),
    .fast_watch_btn (fast_watch_btn),
    .reset_count    (reset_count),
    .load_new_a     (load_new_a),
    .load_new_c     (load_new_c),
    .show_a         (show_a),
    .show_new_time  (show_new_time),
    .shift          (shift),
    .fast_watch     (fast_watch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         test;
    int         step;
    logic [6:0] exp;
  } sb_t;

  sb_t        sbq[$];
  sb_t        cur;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         test_id = 0;
  int         step_id = 0;
  logic [6:0] obs;

  assign obs = {reset_count, load_new_a, load_new_c, show_a, show_new_time, shift, fast_watch};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      cur = sbq.pop_front();
      total++;
      if (cur.due != cyc || obs !== cur.exp) begin
        bad++;
        $display("FAIL test%0d step%0d outputs: got %b want %b (cycle %0d due %0d)",
                 cur.test, cur.step, obs, cur.exp, cyc, cur.due);
      end
    end
  end

  task automatic step(input logic rst, input logic os, input logic [3:0] k,
                      input logic ab, input logic tbtn, input logic fw,
                      input logic [6:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    one_second     = os;
    key            = k;
    alarm_button   = ab;
    time_button    = tbtn;
    fast_watch_btn = fw;
    step_id++;
    e.due  = cyc + 1;
    e.test = test_id;
    e.step = step_id;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic kst(input logic [3:0] k, input logic [6:0] exp);
    step(1'b0, 1'b0, k, 1'b0, 1'b0, 1'b0, exp);
  endtask

  // one_second pulse followed by a quiet cycle, key held at k throughout
  task automatic pulse_gap(input logic [3:0] k, input logic [6:0] exp);
    step(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0, exp);
    step(1'b0, 1'b0, k, 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    // 1: reset, then reset held two cycles in KEY_ENTRY with a digit present
    test_id = 1;
    step(1, 0, NK, 0, 0, 0, E_IDLE);
    kst(NK, E_IDLE);
    kst(4'd5, E_SHIFT);
    kst(NK, E_NEW);
    kst(NK, E_NEW);
    step(1, 0, 4'd5, 0, 0, 0, E_IDLE);
    step(1, 0, 4'd5, 0, 0, 0, E_IDLE);
    kst(NK, E_IDLE);

    // 2: key 3 held 4 cycles, released, then time button loads current time
    test_id = 2;
    kst(4'd3, E_SHIFT);
    kst(4'd3, E_NEW);
    kst(4'd3, E_NEW);
    kst(4'd3, E_NEW);
    kst(NK, E_NEW);
    step(0, 0, NK, 0, 1, 0, E_LDC);
    step(0, 0, NK, 0, 1, 0, E_IDLE);
    kst(NK, E_IDLE);

    // 3: digit 7 then idle; 10th one_second pulse ends key entry
    test_id = 3;
    kst(4'd7, E_SHIFT);
    kst(NK, E_NEW);
    for (int i = 0; i < 9; i++) pulse_gap(NK, E_NEW);
    step(0, 1, NK, 0, 0, 0, E_NEW);
    kst(NK, E_IDLE);
    kst(NK, E_IDLE);

    // 4: 9 pulses, then digit 2 restarts the timeout
    test_id = 4;
    kst(4'd4, E_SHIFT);
    kst(NK, E_NEW);
    for (int i = 0; i < 9; i++) pulse_gap(NK, E_NEW);
    kst(4'd2, E_SHIFT);
    kst(NK, E_NEW);
    for (int i = 0; i < 9; i++) pulse_gap(NK, E_NEW);
    step(0, 1, NK, 0, 0, 0, E_NEW);
    kst(NK, E_IDLE);

    // 4b: timeout while the digit is still held (KEY_WAITED), code 12 is no key
    test_id = 41;
    kst(4'd6, E_SHIFT);
    kst(4'd6, E_NEW);
    for (int i = 0; i < 9; i++) pulse_gap(4'd6, E_NEW);
    step(0, 1, 4'd6, 0, 0, 0, E_NEW);
    kst(4'd6, E_IDLE);
    kst(4'd12, E_IDLE);
    kst(4'd12, E_IDLE);

    // 5: alarm button held 5 cycles in SHOW_TIME, beats a digit, ignores keys
    test_id = 5;
    step(0, 0, 4'd5, 1, 0, 0, E_SHA);
    step(0, 0, NK, 1, 0, 0, E_SHA);
    step(0, 0, 4'd8, 1, 0, 0, E_SHA);
    step(0, 0, NK, 1, 0, 0, E_SHA);
    step(0, 0, NK, 1, 0, 0, E_SHA);
    kst(NK, E_IDLE);
    kst(NK, E_IDLE);

    // 5b: alarm and time together in KEY_ENTRY -> alarm load, one cycle only
    test_id = 51;
    kst(4'd1, E_SHIFT);
    kst(NK, E_NEW);
    kst(4'd15, E_NEW);
    step(0, 0, NK, 1, 1, 0, E_LDA);
    step(0, 0, NK, 1, 0, 0, E_IDLE);
    step(0, 0, NK, 1, 0, 0, E_SHA);
    kst(NK, E_IDLE);

    // 6: fast watch follows the button only in SHOW_TIME
    test_id = 6;
    step(0, 0, NK, 0, 0, 1, E_FW);
    step(0, 0, NK, 0, 0, 1, E_FW);
    step(0, 0, 4'd8, 0, 0, 1, E_SHIFT);
    step(0, 0, NK, 0, 0, 1, E_NEW);
    step(0, 0, NK, 0, 0, 1, E_NEW);
    step(1, 0, NK, 0, 0, 1, E_IDLE);
    step(0, 0, NK, 0, 0, 1, E_FW);
    kst(NK, E_IDLE);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected responses never checked, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
